// File: rtl/ripple_cnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ripple_cnt_monitor
// Description : Synchronous consumer for an asynchronous ripple up-counter.
//               Double-flop synchronizes the raw count and waits until it has
//               been stable long enough before accepting it. Each accepted
//               step is then checked for wrap-around and for skipped counts,
//               and added to a saturating event total.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_cnt_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int EVT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] stable_cnt,
  output logic             cnt_valid,
  output logic             wrap_pulse,
  output logic             skip_err,
  output logic [EVT_W-1:0] total_events
);

  // The sum is wide enough to hold either operand plus a carry, so saturation
  // can be detected by a plain compare against the accumulator maximum.
  localparam int              c_SW        = ((EVT_W > WIDTH) ? EVT_W : WIDTH) + 1;
  localparam logic [3:0]      c_STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0]      c_STABLE_M1 = 4'(STABLE_CYCLES - 1);
  localparam logic [c_SW-1:0] c_EVT_MAX   = {{(c_SW-EVT_W){1'b0}}, {EVT_W{1'b1}}};
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ONES     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [3:0]       r_run;
  logic [WIDTH-1:0] r_stable_cnt;
  logic             r_cnt_valid;
  logic             r_wrap_pulse;
  logic             r_skip_err;
  logic [EVT_W-1:0] r_total_events;

  logic             w_match;
  logic             w_accept;
  logic [WIDTH-1:0] w_step;
  logic [c_SW-1:0]  w_sum;
  logic [EVT_W-1:0] w_total_next;
  logic             w_wrap;
  logic             w_skip;

  // A value is accepted on the edge its run of matching samples first
  // reaches the required length; later matches only hold the saturated run.
  assign w_match  = (r_sync2 == r_cand);
  assign w_accept = en && (r_state != S_IDLE) && w_match && (r_run == c_STABLE_M1);
  assign w_step   = r_sync2 - r_stable_cnt;
  assign w_sum    = {{(c_SW-EVT_W){1'b0}}, r_total_events} + {{(c_SW-WIDTH){1'b0}}, w_step};
  assign w_total_next = (w_sum > c_EVT_MAX) ? {EVT_W{1'b1}} : w_sum[EVT_W-1:0];
  assign w_wrap   = (r_stable_cnt == c_ONES) && (r_sync2 == '0);
  assign w_skip   = (w_step > c_ONE);

  // Two-flop synchronizer plus the previous-sample register used for matching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
    end else begin
      r_sync1 <= cnt_in;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
    end
  end

  // Control FSM: stability run counter, acceptance and step evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_run          <= '0;
      r_stable_cnt   <= '0;
      r_cnt_valid    <= 1'b0;
      r_wrap_pulse   <= 1'b0;
      r_skip_err     <= 1'b0;
      r_total_events <= '0;
    end else begin
      r_cnt_valid  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      // A clear is overridden below when a new skip lands on the same edge.
      if (err_clr) begin
        r_skip_err <= 1'b0;
      end
      if (!en) begin
        r_state <= S_IDLE;
        r_run   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ACQUIRE;
            r_run   <= '0;
          end
          S_ACQUIRE, S_TRACK: begin
            if (!w_match) begin
              r_run <= '0;
            end else if (r_run != c_STABLE) begin
              r_run <= r_run + 4'd1;
            end
            if (w_accept) begin
              if (r_state == S_ACQUIRE) begin
                // First value of a session is taken as the reference only.
                r_stable_cnt <= r_sync2;
                r_cnt_valid  <= 1'b1;
                r_state      <= S_TRACK;
              end else if (w_step != '0) begin
                r_stable_cnt   <= r_sync2;
                r_cnt_valid    <= 1'b1;
                r_wrap_pulse   <= w_wrap;
                r_total_events <= w_total_next;
                if (w_skip) begin
                  r_skip_err <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  assign stable_cnt   = r_stable_cnt;
  assign cnt_valid    = r_cnt_valid;
  assign wrap_pulse   = r_wrap_pulse;
  assign skip_err     = r_skip_err;
  assign total_events = r_total_events;

endmodule
`default_nettype wire

// File: tb/tb_ripple_cnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_cnt_monitor
// Description : Self-checking bench for ripple_cnt_monitor. A default
//               instance and a narrow-accumulator instance share stimulus;
//               an edge-indexed behavioural model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_cnt_monitor;

  localparam int c_STABLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] cnt_in = 4'd0;

  logic [3:0]  stable_cnt;
  logic        cnt_valid;
  logic        wrap_pulse;
  logic        skip_err;
  logic [15:0] total_events;

  logic [3:0]  stable_cnt_s;
  logic        cnt_valid_s;
  logic        wrap_pulse_s;
  logic        skip_err_s;
  logic [3:0]  total_events_s;

  int tests = 0;
  int fails = 0;

  ripple_cnt_monitor #(.WIDTH(4), .STABLE_CYCLES(c_STABLE), .EVT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .cnt_in(cnt_in),
    .stable_cnt(stable_cnt), .cnt_valid(cnt_valid), .wrap_pulse(wrap_pulse),
    .skip_err(skip_err), .total_events(total_events)
  );

  ripple_cnt_monitor #(.WIDTH(4), .STABLE_CYCLES(c_STABLE), .EVT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .cnt_in(cnt_in),
    .stable_cnt(stable_cnt_s), .cnt_valid(cnt_valid_s), .wrap_pulse(wrap_pulse_s),
    .skip_err(skip_err_s), .total_events(total_events_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // samp[i] is cnt_in as seen by clock edge i (edges counted from reset).
  // The synchronized value visible after edge i is samp[i-1].
  int samp[$];
  int k;
  int m_mode;        // 0 disabled, 1 first value pending, 2 tracking
  int last_break;    // latest edge that broke the stable streak
  int m_stable, m_total;
  bit m_valid, m_wrap, m_skip;

  function automatic int sv(int idx);
    return (idx >= 1) ? samp[idx-1] : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp.delete();
      k = 0; m_mode = 0; last_break = -1;
      m_stable = 0; m_total = 0; m_valid = 0; m_wrap = 0; m_skip = 0;
    end else begin
      bit elig, mt, acc;
      int v, st;
      elig = en && (m_mode != 0);
      mt   = (sv(k-1) == sv(k-2));
      if (!elig || !mt) last_break = k;
      acc  = elig && mt && ((k - last_break) == c_STABLE);
      v    = sv(k-1);
      m_valid = 0;
      m_wrap  = 0;
      if (err_clr) m_skip = 0;
      if (acc) begin
        if (m_mode == 1) begin
          m_stable = v; m_valid = 1; m_mode = 2;
        end else begin
          st = (v - m_stable + 16) % 16;
          if (st != 0) begin
            m_valid = 1;
            m_wrap  = (m_stable == 15) && (v == 0);
            if (st > 1) m_skip = 1;
            m_total += st;
            m_stable = v;
          end
        end
      end
      if (!en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      samp.push_back(int'(cnt_in));
      k++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("stable_cnt", stable_cnt, m_stable);
    chk("cnt_valid", cnt_valid, m_valid);
    chk("wrap_pulse", wrap_pulse, m_wrap);
    chk("skip_err", skip_err, m_skip);
    chk("total_events", total_events, (m_total > 65535) ? 65535 : m_total);
    chk("sat.stable_cnt", stable_cnt_s, m_stable);
    chk("sat.total_events", total_events_s, (m_total > 15) ? 15 : m_total);
  end

  // Pulse counters for the directed literal checks.
  int pv = 0;
  int pw = 0;
  always @(negedge clk) begin
    if (cnt_valid) pv++;
    if (wrap_pulse) pw++;
  end

  task automatic hold(input int v, input int n);
    cnt_in = 4'(v);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Enable with a steady zero: exactly one acquire pulse, nothing else.
    en = 1'b1; pv = 0; pw = 0;
    repeat (8) @(negedge clk);
    chk("lit.acq_pulses", pv, 1);
    chk("lit.acq_stable", stable_cnt, 0);
    chk("lit.acq_wrap", pw, 0);
    chk("lit.acq_skip", skip_err, 0);
    chk("lit.acq_total", total_events, 0);

    // Full count sequence 1..15,0 with latency measured on the first step.
    pv = 0; pw = 0;
    for (int v = 1; v <= 16; v++) begin
      cnt_in = 4'(v % 16);
      if (v == 1) begin
        lat = -1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (cnt_valid && lat < 0) lat = i;
        end
      end else begin
        repeat (8) @(negedge clk);
      end
    end
    chk("lit.latency", lat, 4);
    chk("lit.seq_pulses", pv, 16);
    chk("lit.seq_wraps", pw, 1);
    chk("lit.seq_total", total_events, 16);
    chk("lit.seq_total_sat", total_events_s, 15);
    chk("lit.seq_skip", skip_err, 0);

    // Glitch to 2 for a single cycle on the way from 3 to 4.
    hold(1, 8); hold(2, 8); hold(3, 8);
    pv = 0;
    hold(2, 1);
    hold(4, 8);
    chk("lit.glitch_pulses", pv, 1);
    chk("lit.glitch_stable", stable_cnt, 4);
    chk("lit.glitch_total", total_events, 20);
    chk("lit.glitch_skip", skip_err, 0);

    // Skip 5->8, clear, then a skip coinciding with err_clr.
    hold(5, 8); hold(8, 8);
    chk("lit.skip_set", skip_err, 1);
    chk("lit.skip_total", total_events, 24);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit.skip_clr", skip_err, 0);
    hold(9, 8);
    cnt_in = 4'd12;
    repeat (4) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("lit.coinc_valid", cnt_valid, 1);
    repeat (6) @(negedge clk);
    chk("lit.coinc_skip", skip_err, 1);
    chk("lit.coinc_total", total_events, 28);
    chk("lit.coinc_stable", stable_cnt, 12);

    // Enable gaps: the value after re-enable is taken without step checks.
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    en = 1'b0; hold(7, 4); en = 1'b1; repeat (8) @(negedge clk);
    chk("lit.gap1_stable", stable_cnt, 7);
    chk("lit.gap1_total", total_events, 28);
    en = 1'b0; hold(11, 3); en = 1'b1; repeat (8) @(negedge clk);
    chk("lit.gap2_stable", stable_cnt, 11);
    chk("lit.gap2_total", total_events, 28);
    chk("lit.gap2_skip", skip_err, 0);

    // Randomized segments checked by the model every cycle.
    for (int s = 0; s < 300; s++) begin
      int n;
      cnt_in = 4'($urandom % 16);
      if (($urandom % 10) == 0) en = ~en;
      n = $urandom_range(1, 10);
      repeat (n) begin
        err_clr = (($urandom % 16) == 0);
        @(negedge clk);
      end
    end
    err_clr = 1'b0; en = 1'b1;
    repeat (10) @(negedge clk);

    // Reset in the middle of qualifying a new value.
    cnt_in = 4'(stable_cnt + 4'd3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit.rst_stable", stable_cnt, 0);
    chk("lit.rst_valid", cnt_valid, 0);
    chk("lit.rst_wrap", wrap_pulse, 0);
    chk("lit.rst_skip", skip_err, 0);
    chk("lit.rst_total", total_events, 0);
    chk("lit.rst_total_sat", total_events_s, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ripple_cnt_monitor.md
# ripple_cnt_monitor

Synchronous consumer stage for the 4-bit asynchronous ripple up-counter. It brings the counter's ripple-settling outputs into the system clock domain through a 2-flop synchronizer and a stability qualifier. Once a value has been stable long enough, the block accepts it and publishes a clean count. For each accepted step it flags wrap-around and detects skipped counts. It also keeps a saturating running total of counted events.

## Interface
- WIDTH, 4, width of the monitored ripple count
- STABLE_CYCLES, 2, consecutive matching synchronized samples needed to accept a value; legal range 1..15
- EVT_W, 16, width of the total event accumulator
- clk  input  1  system clock; unrelated to the ripple counter's clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  monitor enable
- err_clr  input  1  clears sticky skip_err
- cnt_in  input  WIDTH  raw ripple-counter outputs; asynchronous to clk and may show transient codes
- stable_cnt  output  WIDTH  last accepted count
- cnt_valid  output  1  one-cycle pulse on each accepted value change
- wrap_pulse  output  1  one-cycle pulse on an accepted all-ones -> 0 step
- skip_err  output  1  sticky; an accepted step was greater than 1
- total_events  output  EVT_W  saturating sum of accepted steps

## Operation
- Synchronizer: sync1 <= cnt_in, sync2 <= sync1 on every edge, regardless of en.
- Stability qualifier:
  - cand <= sync2 every edge.
  - match = (sync2 == cand).
  - run (4 bits) is held at 0 in IDLE.
  - Outside IDLE, a mismatch clears run to 0. A match increments run, saturating at STABLE_CYCLES.
  - Accept occurs on the edge where run goes from STABLE_CYCLES-1 to STABLE_CYCLES. The accepted value is sync2.
- State machine:
  - IDLE: en=0. No accepts. Outputs hold. Next state is ACQUIRE when en=1.
  - ACQUIRE: on accept, stable_cnt <= value, cnt_valid pulses, and the state moves to TRACK. No step evaluation, no wrap, no error, no total update.
  - TRACK: on accept, compute step = (value - stable_cnt) mod 2^WIDTH.
    - step=0: no outputs change and no pulse.
    - step>=1: stable_cnt <= value, cnt_valid pulses, and total_events += step, saturating at 2^EVT_W-1.
    - stable_cnt was all ones and value=0: wrap_pulse pulses with cnt_valid.
    - step>1: skip_err is set. A jump through zero, such as 14->1, sets skip_err and does not pulse wrap_pulse.
  - Any state: en=0 moves the state to IDLE on the next edge and clears run. stable_cnt, skip_err and total_events are held. Re-enabling goes through ACQUIRE, so the first value after re-enable is never step-checked.
- err_clr clears skip_err on the next edge. If a new skip is detected on the same edge, set wins and skip_err stays 1.
- A value that toggles before qualifying is never accepted, and it causes no pulse or error.

## Timing
- All outputs are registered and reset asynchronously:
  - stable_cnt=0, cnt_valid=0, wrap_pulse=0, skip_err=0, total_events=0.
  - Internally, sync1=sync2=cand=0, run=0, state=IDLE.
- TRACK latency: a new cnt_in value is stable before edge E0 and held. stable_cnt and cnt_valid update at edge E(STABLE_CYCLES+2). With the defaults that is E4.
- Inputs that change faster than once per STABLE_CYCLES+2 clk cycles can be missed. A missed value appears as a skip on the next accepted value; that is the intended detection.
- cnt_valid and wrap_pulse are high for exactly one cycle per accept. Consecutive accepts cannot be closer than STABLE_CYCLES+1 cycles apart.
- Reset asserted mid-acquire or mid-track returns the block to its reset state immediately, with no pulse.

## Test plan
- Reset, then en=1 with cnt_in=0 -> exactly one cnt_valid pulse with stable_cnt=0; wrap_pulse=0, skip_err=0, total_events=0.
- Step cnt_in 0->1->2->...->15->0, each value held 8 cycles -> 16 cnt_valid pulses; the pulse for 1 arrives 4 cycles after the change; one wrap_pulse on 15->0; total_events=16; skip_err=0.
- Glitch: from stable 3, cnt_in shows 2 for 1 cycle, then settles to 4 -> no acceptance of 2, one pulse for 4, total_events +1, skip_err=0.
- Skip: from stable 5, jump to 8 -> cnt_valid pulses, skip_err=1, total_events +3. Pulse err_clr with no new skip -> skip_err=0. Pulse err_clr on the same edge as the accept of a 9->12 jump -> skip_err stays 1.
- Enable gap: from stable 7, en=0, cnt_in->11, en=1 -> stable_cnt=11 accepted via ACQUIRE; skip_err unchanged; total_events unchanged.
- Saturation with EVT_W=4: repeat 1-steps past 15 events -> total_events holds 15. Assert rst mid-qualification -> all outputs return to 0 at once.
